// File: rtl/tlb_pkg.sv
// Shared types for the TLB management-op controller: the packed TLB entry,
// op encodings, FSM states and small helper functions.
package tlb_pkg;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } op_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [4:0] INV_OP_MAX = 5'd6;

    // Encodings 5-7 are reserved, and INVTLB only defines ops 0..6.
    function automatic logic op_is_illegal(input logic [2:0] op, input logic [4:0] inv_op);
        logic ill;
        ill = 1'b0;
        if (op > 3'd4) begin
            ill = 1'b1;
        end else if ((op == 3'd4) && (inv_op > INV_OP_MAX)) begin
            ill = 1'b1;
        end else begin
            ill = 1'b0;
        end
        return ill;
    endfunction

    function automatic tlb_entry_t entry_with_e(input tlb_entry_t ent, input logic ne);
        tlb_entry_t r;
        r   = ent;
        r.e = ~ne;
        return r;
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Request/response interface between the pipeline/CSR unit (master) and the
// TLB management-op controller (slave).
interface tlb_op_ctrl_if #(
    parameter int IDXW = 4
) ();

    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            op_type;
    logic [4:0]            inv_op;
    logic [9:0]            inv_asid;
    logic [18:0]           inv_vppn;
    logic [IDXW-1:0]       csr_index;
    logic                  csr_ne;
    tlb_pkg::tlb_entry_t   csr_entry;
    logic [9:0]            csr_asid;
    logic [18:0]           csr_vppn;

    logic                  done;
    logic                  res_found;
    logic [IDXW-1:0]       res_index;
    tlb_pkg::tlb_entry_t   res_entry;
    logic                  err_ill;

    modport master (
        output op_valid, op_type, inv_op, inv_asid, inv_vppn,
               csr_index, csr_ne, csr_entry, csr_asid, csr_vppn,
        input  op_ready, done, res_found, res_index, res_entry, err_ill
    );

    modport slave (
        input  op_valid, op_type, inv_op, inv_asid, inv_vppn,
               csr_index, csr_ne, csr_entry, csr_asid, csr_vppn,
        output op_ready, done, res_found, res_index, res_entry, err_ill
    );

endinterface

// File: rtl/tlb_fill_ptr.sv
// Round-robin TLBFILL victim pointer: wraps from TLBNUM-1 back to 0 on each
// enabled increment.
module tlb_fill_ptr #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    output logic [IDXW-1:0] ptr
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;

    // Next pointer value.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            if (ptr_q == LAST_IDX) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + {{(IDXW-1){1'b0}}, 1'b1};
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: IDLE -> EXEC -> RESP.
// Optional TLB_PERF_EN adds FILL and INVTLB event counters.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    tlb_op_ctrl_if.slave    op_if,

    output logic            s1_grant,
    output logic [18:0]     s1_vppn_o,
    output logic [9:0]      s1_asid_o,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_index,

    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output tlb_entry_t      tlb_w_entry,
    output logic [IDXW-1:0] tlb_r_index,
    input  tlb_entry_t      tlb_r_entry,

    output logic            invtlb_valid,
    output logic [4:0]      invtlb_op
`ifdef TLB_PERF_EN
    ,
    output logic [31:0]     perf_fill_cnt,
    output logic [31:0]     perf_inv_cnt
`endif
);

    state_e          state_q,     state_d;
    logic [2:0]      op_q,        op_d;
    logic [4:0]      inv_op_q,    inv_op_d;
    logic [9:0]      inv_asid_q,  inv_asid_d;
    logic [18:0]     inv_vppn_q,  inv_vppn_d;
    logic [IDXW-1:0] csr_index_q, csr_index_d;
    logic            csr_ne_q,    csr_ne_d;
    tlb_entry_t      csr_entry_q, csr_entry_d;
    logic [9:0]      csr_asid_q,  csr_asid_d;
    logic [18:0]     csr_vppn_q,  csr_vppn_d;

    logic            res_found_q, res_found_d;
    logic [IDXW-1:0] res_index_q, res_index_d;
    tlb_entry_t      res_entry_q, res_entry_d;
    logic            err_ill_q,   err_ill_d;

    logic            ill_s;
    logic            fill_inc_s;
    logic [IDXW-1:0] fill_ptr_s;

    assign ill_s = op_is_illegal(op_q, inv_op_q);

    tlb_fill_ptr #(
        .TLBNUM (TLBNUM),
        .IDXW   (IDXW)
    ) u_fill_ptr (
        .clk    (clk),
        .reset  (reset),
        .inc    (fill_inc_s),
        .ptr    (fill_ptr_s)
    );

    // Next state, request capture and result capture.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        inv_op_d    = inv_op_q;
        inv_asid_d  = inv_asid_q;
        inv_vppn_d  = inv_vppn_q;
        csr_index_d = csr_index_q;
        csr_ne_d    = csr_ne_q;
        csr_entry_d = csr_entry_q;
        csr_asid_d  = csr_asid_q;
        csr_vppn_d  = csr_vppn_q;
        res_found_d = res_found_q;
        res_index_d = res_index_q;
        res_entry_d = res_entry_q;
        err_ill_d   = err_ill_q;

        case (state_q)
            ST_IDLE: begin
                if (op_if.op_valid) begin
                    state_d     = ST_EXEC;
                    op_d        = op_if.op_type;
                    inv_op_d    = op_if.inv_op;
                    inv_asid_d  = op_if.inv_asid;
                    inv_vppn_d  = op_if.inv_vppn;
                    csr_index_d = op_if.csr_index;
                    csr_ne_d    = op_if.csr_ne;
                    csr_entry_d = op_if.csr_entry;
                    csr_asid_d  = op_if.csr_asid;
                    csr_vppn_d  = op_if.csr_vppn;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Results are rebuilt for every op so stale SRCH/RD data never leaks.
                state_d     = ST_RESP;
                res_found_d = 1'b0;
                res_index_d = '0;
                res_entry_d = '0;
                err_ill_d   = ill_s;
                if (!ill_s) begin
                    case (op_q)
                        OP_SRCH: begin
                            res_found_d = s1_found;
                            res_index_d = s1_index;
                        end
                        OP_RD: begin
                            res_found_d = tlb_r_entry.e;
                            res_entry_d = tlb_r_entry;
                        end
                        default: begin
                            res_found_d = 1'b0;
                        end
                    endcase
                end else begin
                    res_found_d = 1'b0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // TLB port drive, decoded only from registered state and latched request.
    always_comb begin
        s1_grant     = 1'b0;
        s1_vppn_o    = 19'd0;
        s1_asid_o    = 10'd0;
        tlb_we       = 1'b0;
        tlb_w_index  = '0;
        tlb_w_entry  = '0;
        tlb_r_index  = '0;
        invtlb_valid = 1'b0;
        invtlb_op    = 5'd0;
        fill_inc_s   = 1'b0;

        if ((state_q == ST_EXEC) && !ill_s) begin
            case (op_q)
                OP_SRCH: begin
                    s1_grant  = 1'b1;
                    s1_vppn_o = csr_vppn_q;
                    s1_asid_o = csr_asid_q;
                end
                OP_RD: begin
                    tlb_r_index = csr_index_q;
                end
                OP_WR: begin
                    tlb_we      = 1'b1;
                    tlb_w_index = csr_index_q;
                    tlb_w_entry = entry_with_e(csr_entry_q, csr_ne_q);
                end
                OP_FILL: begin
                    tlb_we      = 1'b1;
                    tlb_w_index = fill_ptr_s;
                    tlb_w_entry = entry_with_e(csr_entry_q, csr_ne_q);
                    fill_inc_s  = 1'b1;
                end
                OP_INV: begin
                    s1_grant     = 1'b1;
                    s1_vppn_o    = inv_vppn_q;
                    s1_asid_o    = inv_asid_q;
                    invtlb_op    = inv_op_q;
                    invtlb_valid = 1'b1;
                end
                default: begin
                    s1_grant = 1'b0;
                end
            endcase
        end else begin
            s1_grant = 1'b0;
        end
    end

    // FSM, latched request and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            inv_op_q    <= 5'd0;
            inv_asid_q  <= 10'd0;
            inv_vppn_q  <= 19'd0;
            csr_index_q <= '0;
            csr_ne_q    <= 1'b0;
            csr_entry_q <= '0;
            csr_asid_q  <= 10'd0;
            csr_vppn_q  <= 19'd0;
            res_found_q <= 1'b0;
            res_index_q <= '0;
            res_entry_q <= '0;
            err_ill_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            inv_op_q    <= inv_op_d;
            inv_asid_q  <= inv_asid_d;
            inv_vppn_q  <= inv_vppn_d;
            csr_index_q <= csr_index_d;
            csr_ne_q    <= csr_ne_d;
            csr_entry_q <= csr_entry_d;
            csr_asid_q  <= csr_asid_d;
            csr_vppn_q  <= csr_vppn_d;
            res_found_q <= res_found_d;
            res_index_q <= res_index_d;
            res_entry_q <= res_entry_d;
            err_ill_q   <= err_ill_d;
        end
    end

    assign op_if.op_ready  = (state_q == ST_IDLE);
    assign op_if.done      = (state_q == ST_RESP);
    assign op_if.res_found = res_found_q;
    assign op_if.res_index = res_index_q;
    assign op_if.res_entry = res_entry_q;
    assign op_if.err_ill   = err_ill_q;

`ifdef TLB_PERF_EN
    logic [31:0] perf_fill_cnt_q, perf_fill_cnt_d;
    logic [31:0] perf_inv_cnt_q,  perf_inv_cnt_d;

    // Event counters wrap naturally at 2^32.
    always_comb begin
        perf_fill_cnt_d = perf_fill_cnt_q;
        perf_inv_cnt_d  = perf_inv_cnt_q;
        if (fill_inc_s) begin
            perf_fill_cnt_d = perf_fill_cnt_q + 32'd1;
        end else begin
            perf_fill_cnt_d = perf_fill_cnt_q;
        end
        if (invtlb_valid) begin
            perf_inv_cnt_d = perf_inv_cnt_q + 32'd1;
        end else begin
            perf_inv_cnt_d = perf_inv_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fill_cnt_q <= 32'd0;
            perf_inv_cnt_q  <= 32'd0;
        end else begin
            perf_fill_cnt_q <= perf_fill_cnt_d;
            perf_inv_cnt_q  <= perf_inv_cnt_d;
        end
    end

    assign perf_fill_cnt = perf_fill_cnt_q;
    assign perf_inv_cnt  = perf_inv_cnt_q;
`endif

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequencer for the 16-entry TLB's management instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB.
- Accepts one op at a time from the EX stage and borrows the TLB's search port 1 for TLBSRCH/INVTLB; that port is normally used by load/store.
- Drives the TLB write, read and invtlb ports, then returns results for CSR update (TLBIDX, TLBEHI, TLBELO0/1, ASID).
- Sits between the pipeline/CSR unit and the TLB.

Parameters:
- TLBNUM, 16, TLB entry count; power of two, 2..64.
- IDXW, $clog2(TLBNUM), index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  op request
- op_ready  out  1  controller idle, can accept
- op_type  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 illegal
- inv_op  in  5  INVTLB op field
- inv_asid  in  10  INVTLB rj ASID
- inv_vppn  in  19  INVTLB rk VA[31:13]
- csr_index  in  IDXW  TLBIDX.index
- csr_ne  in  1  TLBIDX.NE
- csr_entry  in  89  packed entry from CSRs (tlb_entry_t); e field ignored
- csr_asid  in  10  ASID.asid
- csr_vppn  in  19  TLBEHI.vppn
- s1_grant  out  1  controller owns TLB search port 1
- s1_vppn_o  out  19  port-1 vppn while granted
- s1_asid_o  out  10  port-1 asid while granted
- s1_found  in  1  TLB port-1 hit
- s1_index  in  IDXW  TLB port-1 hit index
- tlb_we  out  1  TLB write enable
- tlb_w_index  out  IDXW  write index
- tlb_w_entry  out  89  write entry (tlb_entry_t)
- tlb_r_index  out  IDXW  read index
- tlb_r_entry  in  89  read data
- invtlb_valid  out  1  TLB invalidate strobe
- invtlb_op  out  5  invalidate op
- done  out  1  one-cycle completion pulse
- res_found  out  1  SRCH hit / RD entry valid
- res_index  out  IDXW  SRCH hit index
- res_entry  out  89  RD entry
- err_ill  out  1  illegal op_type or inv_op>6, valid with done

Behaviour:
- Reset (async): state IDLE, fill_ptr=0. Every output 0 except op_ready=1.
- States: IDLE -> EXEC -> RESP -> IDLE. Fixed latency: done asserts 2 cycles after the accept edge.
- IDLE: op_ready=1. On op_valid, latch op_type, inv_*, csr_* and move to EXEC. While not IDLE, op_ready=0 and op_valid is ignored; the requester holds it.
- EXEC:
  - SRCH: s1_grant=1, s1_vppn_o=csr_vppn, s1_asid_o=csr_asid. Register s1_found/s1_index.
  - RD: tlb_r_index=csr_index. Register tlb_r_entry. res_found = entry e bit.
  - WR: tlb_we=1 for one cycle. tlb_w_index=csr_index. tlb_w_entry=csr_entry with e=~csr_ne.
  - FILL: same as WR but index=fill_ptr. fill_ptr increments modulo TLBNUM after the write (TLBNUM-1 -> 0).
  - INV: s1_grant=1, s1_vppn_o=inv_vppn, s1_asid_o=inv_asid, invtlb_op=inv_op, invtlb_valid=1 only if inv_op<=6.
- RESP: done=1. res_* and err_ill hold until the next done. Illegal op: no TLB port is driven; err_ill=1.
- s1_grant is high only in EXEC of SRCH/INV. The pipeline stalls load/store TLB lookups while s1_grant=1.
- Reset asserted in EXEC aborts the op: the write/invalidate strobe drops immediately and no done is produced.
- csr_* may change after accept; only the latched copies are used.

Optional Feature:
- TLB_PERF_EN defined: adds 32-bit outputs perf_fill_cnt and perf_inv_cnt. These increment on each FILL write and each legal invtlb_valid, wrap at 2^32, and reset to 0.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package tlb_pkg: tlb_entry_t packed struct {e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0, ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1} = 89 bits.
- Package also holds op_type enum constants and INV_OP_MAX=6.
- One sub-module, tlb_fill_ptr: wrapping counter with increment enable.

Test Plan:
- Reset mid-FILL in EXEC -> tlb_we falls the same cycle; fill_ptr=0; no done; op_ready=1 after reset release.
- WR with csr_index=5, csr_ne=1 -> one-cycle tlb_we, w_index=5, entry e=0; done 2 cycles after accept.
- 17 back-to-back FILLs with TLBNUM=16 -> w_index sequence 0..15, then 0.
- SRCH with model TLB holding vppn 0x12345/asid 3 at index 9 -> s1_grant for 1 cycle; res_found=1, res_index=9. Non-matching vppn -> res_found=0.
- INV inv_op=5, asid 3, vppn 0x12345 -> invtlb_valid 1 cycle with op 5. inv_op=7 -> no strobe; err_ill=1 with done.
- op_valid held through a busy RD -> second op accepted exactly in the cycle after RESP; RD res_entry equals the model's entry at csr_index.
